// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register bank: FSM states, register
// kinds and the byte-strobe merge used by every register cell.
package apb_reg_pkg;

  localparam int unsigned MAX_DW   = 1024;
  localparam int unsigned MAX_STRB = MAX_DW / 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    REG_RW,
    REG_RO,
    REG_W1C
  } reg_type_e;

  // Read-only wins over write-1-to-clear when both mask bits are set.
  function automatic reg_type_e reg_type(input int unsigned i,
                                         input logic [63:0] ro_mask,
                                         input logic [63:0] w1c_mask);
    reg_type_e t;
    t = REG_RW;
    if (i < 64) begin
      if (ro_mask[i[5:0]]) t = REG_RO;
      else if (w1c_mask[i[5:0]]) t = REG_W1C;
    end
    return t;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]   old_v,
                                                   input logic [MAX_DW-1:0]   new_v,
                                                   input logic [MAX_STRB-1:0] strb);
    logic [MAX_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < MAX_STRB; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One bank register: RW byte-merge, RO held at zero (reads come from hardware),
// or W1C sticky bits where a hardware set beats a same-cycle software clear.
module apb_reg_cell
  import apb_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter reg_type_e   RTYPE      = REG_RW
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   hw_set,
  output logic [DATA_WIDTH-1:0]   q
);

  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic                  unused_in;

  // Some register kinds ignore some inputs.
  assign unused_in = ^{hw_set, wdata, wstrb, wr_en};

  always_comb begin
    merged   = DATA_WIDTH'(byte_merge(MAX_DW'(q), MAX_DW'(wdata), MAX_STRB'(wstrb)));
    clr_bits = wr_en ? DATA_WIDTH'(byte_merge('0, MAX_DW'(wdata), MAX_STRB'(wstrb))) : '0;
    q_d      = q;
    case (RTYPE)
      REG_RW:  if (wr_en) q_d = merged;
      REG_W1C: q_d = (q & ~clr_bits) | hw_set;
      default: q_d = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) q <= '0;
    else           q <= q_d;
  end

endmodule

// File: rtl/apb_reg_bank.sv
// APB4 slave register bank: setup/access FSM with programmable wait states,
// address decode with pslverr, read mux and per-register write pulses.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(10'h014),
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [63:0]           RO_MASK     = 64'h80,
  parameter logic [63:0]           W1C_MASK    = 64'h40
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_event
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W  = 4;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  latch_en, commit;
  logic                  write_q, err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic [NUM_REGS-1:0]   pulse_d;

  logic [ADDR_WIDTH-1:0] off, idx_full;
  logic [IDX_W-1:0]      idx_live, sel_idx;
  logic                  err_live, sel_err, sel_write;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_REGS-1:0]   is_ro;
  logic [DATA_WIDTH-1:0] q_arr  [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw_arr [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_type_e RT = reg_type(i, RO_MASK, W1C_MASK);

    assign is_ro[i]  = (RT == REG_RO);
    assign hw_arr[i] = hw_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q_arr[i];

    apb_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RTYPE      (RT)
    ) u_cell (
      .pclk     (pclk),
      .preset_n (preset_n),
      .wr_en    (commit && (idx_q == IDX_W'(i))),
      .wdata    (wdata_q),
      .wstrb    (strb_q),
      .hw_set   (hw_event[i*DATA_WIDTH +: DATA_WIDTH]),
      .q        (q_arr[i])
    );
  end

  // Decode the live bus in setup, the latched transfer during access.
  always_comb begin
    off       = paddr - BASE_ADDR;
    idx_full  = off >> 2;
    idx_live  = IDX_W'(idx_full);
    err_live  = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
                (idx_full >= ADDR_WIDTH'(NUM_REGS)) || (pwrite && is_ro[idx_live]);
    sel_idx   = (state_q == IDLE) ? idx_live : idx_q;
    sel_err   = (state_q == IDLE) ? err_live : err_q;
    sel_write = (state_q == IDLE) ? pwrite   : write_q;
    rd_word   = is_ro[sel_idx] ? hw_arr[sel_idx] : q_arr[sel_idx];
  end

  // pready/pslverr/prdata are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    commit    = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    pulse_d   = '0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          latch_en = 1'b1;
          state_d  = ACCESS;
          cnt_d    = CNT_W'(WAIT_STATES);
          pready_d = (WAIT_STATES == 0);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pready) begin
          state_d = IDLE;
          commit  = write_q && !err_q;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          pready_d = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    if (pready_d) begin
      pslverr_d = sel_err;
      prdata_d  = (sel_err || sel_write) ? '0 : rd_word;
    end
    if (commit) pulse_d[idx_q] = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pready       <= 1'b0;
      pslverr      <= 1'b0;
      prdata       <= '0;
      reg_wr_pulse <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pready       <= pready_d;
      pslverr      <= pslverr_d;
      prdata       <= prdata_d;
      reg_wr_pulse <= pulse_d;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (latch_en) begin
      write_q <= pwrite;
      err_q   <= err_live;
      idx_q   <= idx_live;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Scoreboard bench: a zero-wait bank under random APB traffic against an
// array model, plus a three-wait-state bank for timing, abort and reset.
module tb_apb_reg_bank;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned SW = 4;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              preset_n;
  logic              psel0, psel3, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [NR*DW-1:0]  hw_rdata, hw_event;
  logic              pready0, pslverr0, pready3, pslverr3;
  logic [DW-1:0]     prdata0, prdata3;
  logic [NR*DW-1:0]  reg_q0, reg_q3;
  logic [NR-1:0]     pulse0, pulse3;

  apb_reg_bank #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .reg_q(reg_q0), .reg_wr_pulse(pulse0), .hw_rdata(hw_rdata),
    .hw_event(hw_event));

  apb_reg_bank #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready3), .prdata(prdata3),
    .pslverr(pslverr3), .reg_q(reg_q3), .reg_wr_pulse(pulse3), .hw_rdata(hw_rdata),
    .hw_event(hw_event));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  pulse;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_reg [NR];
  logic [31:0] model_hw7;
  logic [7:0]  pulse_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic [9:0] a, input logic wr);
    int idx;
    if (a[1:0] != 2'b00) return 1'b1;
    if (int'(a) < 20) return 1'b1;
    idx = (int'(a) - 20) / 4;
    if (idx >= NR) return 1'b1;
    if (wr && idx == 7) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Register 6 is sticky (clear by writing 1s, set by events); others are plain.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] ev6);
    logic [31:0] m;
    m = strb_mask(s);
    if (idx == 6) model_reg[6] = (model_reg[6] & ~(d & m)) | ev6;
    else begin
      model_reg[idx] = (model_reg[idx] & ~m) | (d & m);
      model_reg[6]   = model_reg[6] | ev6;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_reg[i] = '0;
  endtask

  // One zero-wait transfer on dut0; ev6 is presented to register 6 across the commit edge.
  task automatic xfer0(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ev6);
    exp_t e;
    logic er;
    int   idx;
    int   n;
    er      = model_err(a, wr);
    idx     = er ? 0 : (int'(a) - 20) / 4;
    e.err   = er;
    e.rdata = '0;
    e.pulse = '0;
    if (!er && !wr) e.rdata = (idx == 7) ? model_hw7 : model_reg[idx];
    if (!er && wr)  e.pulse = 8'(1 << idx);
    exp_q.push_back(e);
    psel0 = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    hw_event[6*DW +: DW] = ev6;
    n = 0;
    while (!pready0 && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    check("xfer0_ready", 32'(pready0), 32'd1);
    @(posedge pclk); #1;
    hw_event[6*DW +: DW] = '0;
    psel0 = 1'b0; penable = 1'b0;
    if (!er && wr) model_write(idx, d, s, ev6);
    else           model_reg[6] = model_reg[6] | ev6;
  endtask

  task automatic idle(input int n);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic event6(input logic [31:0] v);
    hw_event[6*DW +: DW] = v;
    @(posedge pclk); #1;
    hw_event[6*DW +: DW] = '0;
    model_reg[6] = model_reg[6] | v;
  endtask

  // One transfer on the three-wait bank, reporting how many access cycles had pready low.
  task automatic x3(input logic wr, input logic [9:0] a, input logic [31:0] d,
                    output int low, output logic [31:0] rd, output logic err,
                    output logic [7:0] pl);
    psel3 = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    low = 0;
    while (!pready3 && low < 20) begin
      @(posedge pclk); #1;
      low++;
    end
    rd  = prdata3;
    err = pslverr3;
    @(posedge pclk); #1;
    pl = pulse3;
    psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic check_regq0();
    for (int i = 0; i < NR; i++)
      check($sformatf("reg_q0[%0d]", i), reg_q0[i*DW +: DW], (i == 7) ? 32'h0 : model_reg[i]);
  endtask

  // Monitor: pops an expectation on every pready and tracks the follow-up write pulse.
  always @(negedge pclk) begin
    if (!preset_n) begin
      pulse_exp = '0;
    end else begin
      check("wr_pulse", 32'(pulse0), 32'(pulse_exp));
      pulse_exp = '0;
      if (pready0) begin
        if (exp_q.size() == 0) begin
          check("spurious_pready", 32'(pready0), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("prdata", prdata0, mon_e.rdata);
          check("pslverr", 32'(pslverr0), 32'(mon_e.err));
          pulse_exp = mon_e.pulse;
        end
      end else begin
        check("prdata_idle", prdata0, 32'h0);
        check("pslverr_idle", 32'(pslverr0), 32'd0);
      end
    end
  end

  initial begin
    int          low;
    logic [31:0] rd;
    logic        er;
    logic [7:0]  pl;
    logic        saw;
    logic        wr;
    logic [9:0]  a;
    int          r;

    preset_n = 1'b0;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; hw_event = '0;
    for (int i = 0; i < NR; i++) hw_rdata[i*DW +: DW] = $urandom;
    model_hw7 = hw_rdata[7*DW +: DW];
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready", 32'(pready0), 32'd0);
    check("rst_pslverr", 32'(pslverr0), 32'd0);
    check("rst_prdata", prdata0, 32'h0);
    check("rst_pulse", 32'(pulse0), 32'd0);
    check("rst_pready3", 32'(pready3), 32'd0);
    check_regq0();
    preset_n = 1'b1;
    idle(2);

    // Directed traffic on the zero-wait bank
    xfer0(1'b1, 10'h014, 32'hDEADBEEF, 4'hF, 32'h0);
    xfer0(1'b0, 10'h014, 32'h0, 4'hF, 32'h0);
    xfer0(1'b1, 10'h018, 32'hAABBCCDD, 4'hF, 32'h0);
    xfer0(1'b1, 10'h018, 32'h11223344, 4'b0101, 32'h0);
    check("strobe_merge", reg_q0[1*DW +: DW], 32'hAA22CC44);
    xfer0(1'b0, 10'h018, 32'h0, 4'hF, 32'h0);
    xfer0(1'b1, 10'h030, 32'h12345678, 4'hF, 32'h0);
    xfer0(1'b0, 10'h030, 32'h0, 4'hF, 32'h0);
    xfer0(1'b0, 10'h015, 32'h0, 4'hF, 32'h0);
    xfer0(1'b0, 10'h100, 32'h0, 4'hF, 32'h0);
    xfer0(1'b0, 10'h010, 32'h0, 4'hF, 32'h0);
    xfer0(1'b1, 10'h034, 32'h0, 4'hF, 32'h0);
    xfer0(1'b1, 10'h014, 32'hFFFFFFFF, 4'h0, 32'h0);
    idle(1);
    event6(32'h5);
    xfer0(1'b0, 10'h02C, 32'h0, 4'hF, 32'h0);
    xfer0(1'b1, 10'h02C, 32'h1, 4'hF, 32'h1);
    check("w1c_set_wins", reg_q0[6*DW +: DW], 32'h5);
    xfer0(1'b1, 10'h02C, 32'h5, 4'hF, 32'h0);
    xfer0(1'b0, 10'h02C, 32'h0, 4'hF, 32'h0);

    // Random traffic, mostly back-to-back
    for (int k = 0; k < 200; k++) begin
      r  = $urandom_range(0, 9);
      a  = (r <= 8) ? 10'(20 + 4 * r) : 10'($urandom);
      wr = 1'($urandom_range(0, 1));
      xfer0(wr, a, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check_regq0();

    // Three wait states: timing, readback, abort, reset mid-access
    x3(1'b1, 10'h014, 32'hCAFE0001, low, rd, er, pl);
    check("ws3_write_low", 32'(low), 32'd3);
    check("ws3_write_err", 32'(er), 32'd0);
    check("ws3_write_pulse", 32'(pl), 32'h01);
    x3(1'b0, 10'h014, 32'h0, low, rd, er, pl);
    check("ws3_read_low", 32'(low), 32'd3);
    check("ws3_read_data", rd, 32'hCAFE0001);
    check("ws3_read_pulse", 32'(pl), 32'h00);

    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h018; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      saw = saw | pready3 | (|pulse3);
      @(posedge pclk); #1;
    end
    check("abort_no_ready_or_pulse", 32'(saw), 32'd0);
    check("abort_reg_held", reg_q3[1*DW +: DW], 32'h0);
    x3(1'b0, 10'h018, 32'h0, low, rd, er, pl);
    check("abort_then_low", 32'(low), 32'd3);
    check("abort_then_data", rd, 32'h0);

    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h01C; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_pready", 32'(pready3), 32'd0);
    check("rst_mid_reg0", reg_q3[0*DW +: DW], 32'h0);
    check_regq0();
    psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      saw = saw | pready3 | (|pulse3);
      @(posedge pclk); #1;
    end
    check("rst_release_quiet", 32'(saw), 32'd0);
    x3(1'b0, 10'h01C, 32'h0, low, rd, er, pl);
    check("rst_release_low", 32'(low), 32'd3);
    check("rst_release_data", rd, 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
